rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we / wa3 / wd3) between three requesters: core writeback (WB), load/store unit (LSU) and debug write (DBG).
- Fixed priority goes to WB. LSU and DBG are served round-robin between themselves.
- A per-requester starvation guard stalls WB when LSU or DBG has waited too long.
- Output is registered: one write per cycle reaches the register file, one cycle after the accepted handshake.

Parameters:
- STARVE_LIMIT, 4, consecutive waiting cycles before LSU/DBG preempts WB (1..15).
- CW, 4, starvation counter width; must satisfy 2**CW > STARVE_LIMIT.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- wb_valid  input  1  WB write request
- wb_addr  input  5  WB destination register
- wb_data  input  32  WB write data
- wb_ready  output  1  WB request accepted this cycle (combinational)
- lsu_valid  input  1  LSU write request
- lsu_addr  input  5  LSU destination register
- lsu_data  input  32  LSU write data
- lsu_ready  output  1  LSU request accepted this cycle (combinational)
- dbg_valid  input  1  debug write request
- dbg_addr  input  5  debug destination register
- dbg_data  input  32  debug write data
- dbg_ready  output  1  debug request accepted this cycle (combinational)
- rf_we  output  1  register file write enable (registered)
- rf_wa  output  5  register file write address (registered)
- rf_wd  output  32  register file write data (registered)
- wb_stall  output  1  WB preempted by a starving requester (combinational)

Behaviour:
- Reset (async, rstn=0):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - Both starvation counters=0; rr_ptr=LSU.
  - All readys=0 while in reset.
- Handshake: transfer occurs when valid && ready.
  - At most one ready is high per cycle.
  - ready never depends on the requester's own addr/data.
  - valid may drop without transfer; no stickiness is required.
- Grant order each cycle:
  1. Starving requester(s): counter == STARVE_LIMIT and valid. If both starve, rr_ptr picks.
  2. WB, if wb_valid.
  3. LSU/DBG by rr_ptr. If only one is valid, that one wins.
- wb_stall = wb_valid && a starving requester is granted.
- Round-robin: after a transfer from LSU, rr_ptr becomes DBG; after a transfer from DBG, it becomes LSU. WB transfers do not move rr_ptr.
- Starvation counter, per requester:
  - Increments each cycle the requester is valid and not granted.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on a transfer or when valid is low.
- Output register:
  - On the edge following a transfer: rf_we <= (addr != 0), rf_wa <= addr, rf_wd <= data.
  - No transfer: rf_we <= 0; rf_wa/rf_wd hold their previous values.
- Writes to x0 are accepted (ready high, counters/rr_ptr update normally) but produce rf_we=0.
- Latency: accepted at edge N, register file written at edge N+1. The core forwards across that one-cycle gap; this block does no forwarding.
- Reset mid-operation: a pending registered write is discarded (rf_we forced to 0) and counters clear.

Decomposition:
- Shared package holds:
  - Requester index constants REQ_WB=0, REQ_LSU=1, REQ_DBG=2 and NUM_REQ=3.
  - Register address width 5 and data width 32.
  - The x0 address constant.
- Natural sub-module: rf_starve_counter (clk, rstn, wait_i, clear_i, starving_o), parameterised by STARVE_LIMIT and CW, instantiated for LSU and DBG.

Test Plan:
- Reset then idle: rstn low for 3 cycles with all valids high → all readys=0 and rf_we=0 throughout. After release, rf_we=0 until the first transfer.
- WB priority: wb_valid=1 (addr=5, data=0xDEADBEEF) with lsu_valid=1 (addr=6) in one cycle → wb_ready=1, lsu_ready=0. Next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF.
- Starvation: wb_valid held high; lsu_valid=1 (addr=7, data=0x11) from cycle 0 with STARVE_LIMIT=4 → lsu_ready=0 in cycles 0–3. In cycle 4, lsu_ready=1, wb_stall=1, wb_ready=0. Cycle 5: rf_wa=7, rf_wd=0x11, and WB resumes.
- Round-robin: lsu_valid and dbg_valid both held, wb_valid=0 → grants alternate LSU, DBG, LSU, DBG, one transfer per cycle. Each produces rf_we=1 the following cycle with the matching addr/data.
- x0 write: dbg_valid=1, dbg_addr=0, dbg_data=0xFFFFFFFF → dbg_ready=1 and next-cycle rf_we=0. rr_ptr advances, shown by LSU winning a following tie.
- Reset mid-write: assert rstn=0 asynchronously in the cycle after a WB transfer (addr=9) → rf_we drops to 0 immediately and no write to x9 occurs.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

  // Requester indices into the grant vector
  localparam int unsigned REQ_WB  = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_DBG = 2;
  localparam int unsigned NUM_REQ = 3;

  // Register file geometry
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  // x0 is hardwired to zero; writes to it are accepted but suppressed
  localparam logic [AW-1:0] X0_ADDR = '0;

  // Round-robin pointer between the two secondary requesters
  typedef enum logic {
    RR_LSU = 1'b0,
    RR_DBG = 1'b1
  } rr_ptr_e;

  function automatic logic is_x0(input logic [AW-1:0] addr);
    return addr == X0_ADDR;
  endfunction

endpackage

// File: rtl/rf_starve_counter.sv
// Saturating wait counter; flags a requester that has waited STARVE_LIMIT cycles.
module rf_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CW           = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic wait_i,
  input  logic clear_i,
  output logic starving_o
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; increment stops at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starving_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB, LSU and debug.
// WB has fixed priority; LSU/DBG alternate round-robin and can preempt WB
// once they have waited STARVE_LIMIT consecutive cycles.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CW           = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_data,
  output logic          lsu_ready,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          wb_stall
);

  logic               lsu_starving;
  logic               dbg_starving;
  logic               lsu_starve;
  logic               dbg_starve;
  logic [NUM_REQ-1:0] gnt;
  logic               starve_gnt;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;

  rr_ptr_e            rr_q;
  rr_ptr_e            rr_d;
  logic               rf_we_q;
  logic [AW-1:0]      rf_wa_q;
  logic [DW-1:0]      rf_wd_q;

  rf_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_lsu_starve (
    .clk        (clk),
    .rstn       (rstn),
    .wait_i     (lsu_valid && !gnt[REQ_LSU]),
    .clear_i    (!lsu_valid || gnt[REQ_LSU]),
    .starving_o (lsu_starving)
  );

  rf_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_dbg_starve (
    .clk        (clk),
    .rstn       (rstn),
    .wait_i     (dbg_valid && !gnt[REQ_DBG]),
    .clear_i    (!dbg_valid || gnt[REQ_DBG]),
    .starving_o (dbg_starving)
  );

  assign lsu_starve = lsu_valid && lsu_starving;
  assign dbg_starve = dbg_valid && dbg_starving;

  // Grant selection: starving requesters, then WB, then LSU/DBG round-robin.
  // Gated by rstn so no ready is raised while reset is asserted.
  always_comb begin
    gnt        = '0;
    starve_gnt = 1'b0;
    if (rstn) begin
      if (lsu_starve && dbg_starve) begin
        starve_gnt = 1'b1;
        if (rr_q == RR_LSU) gnt[REQ_LSU] = 1'b1;
        else                gnt[REQ_DBG] = 1'b1;
      end else if (lsu_starve) begin
        starve_gnt   = 1'b1;
        gnt[REQ_LSU] = 1'b1;
      end else if (dbg_starve) begin
        starve_gnt   = 1'b1;
        gnt[REQ_DBG] = 1'b1;
      end else if (wb_valid) begin
        gnt[REQ_WB] = 1'b1;
      end else if (lsu_valid && dbg_valid) begin
        if (rr_q == RR_LSU) gnt[REQ_LSU] = 1'b1;
        else                gnt[REQ_DBG] = 1'b1;
      end else if (lsu_valid) begin
        gnt[REQ_LSU] = 1'b1;
      end else if (dbg_valid) begin
        gnt[REQ_DBG] = 1'b1;
      end
    end
  end

  // Select the granted request's address/data and advance the round-robin pointer
  always_comb begin
    xfer     = |gnt;
    sel_addr = wb_addr;
    sel_data = wb_data;
    rr_d     = rr_q;
    if (gnt[REQ_LSU]) begin
      sel_addr = lsu_addr;
      sel_data = lsu_data;
      rr_d     = RR_DBG;
    end else if (gnt[REQ_DBG]) begin
      sel_addr = dbg_addr;
      sel_data = dbg_data;
      rr_d     = RR_LSU;
    end
  end

  // Round-robin pointer state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= RR_LSU;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Registered write port; address/data hold when nothing transfers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= xfer && !is_x0(sel_addr);
      if (xfer) begin
        rf_wa_q <= sel_addr;
        rf_wd_q <= sel_data;
      end
    end
  end

  assign wb_ready  = gnt[REQ_WB];
  assign lsu_ready = gnt[REQ_LSU];
  assign dbg_ready = gnt[REQ_DBG];
  assign wb_stall  = wb_valid && starve_gnt;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: the driver pushes model predictions,
// two monitors pop and compare handshakes and register-file writes.
module tb_rf_write_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wb_valid = 1'b0, lsu_valid = 1'b0, dbg_valid = 1'b0;
  logic [4:0]  wb_addr = '0, lsu_addr = '0, dbg_addr = '0;
  logic [31:0] wb_data = '0, lsu_data = '0, dbg_data = '0;
  logic        wb_ready, lsu_ready, dbg_ready, wb_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CW           (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_ready (dbg_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .wb_stall  (wb_stall)
  );

  typedef struct { logic [2:0] rdy; logic stall; } hs_t;
  typedef struct { logic we; logic [4:0] wa; logic [31:0] wd; } wr_t;

  hs_t hs_q[$];
  wr_t wr_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model state: wait counts per requester, next RR favourite
  // (1 = LSU, 2 = DBG), and the register-file write the DUT should present.
  int          m_wait[3];
  int          m_rr = 1;
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the model's prediction for it
  task automatic cycle(input logic r,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    logic        v[3];
    logic [4:0]  a[3];
    logic [31:0] d[3];
    int          g;
    bit          ls, ds;
    hs_t         h;
    wr_t         w;
    @(negedge clk);
    rstn = r;
    wb_valid = wv;  wb_addr = wa;  wb_data = wd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    v[0] = wv; a[0] = wa; d[0] = wd;
    v[1] = lv; a[1] = la; d[1] = ld;
    v[2] = dv; a[2] = da; d[2] = dd;
    if (!r) begin
      m_wait = '{0, 0, 0};
      m_rr = 1;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
      h.rdy = 3'b000;
      h.stall = 1'b0;
    end else begin
      ls = v[1] && (m_wait[1] == LIMIT);
      ds = v[2] && (m_wait[2] == LIMIT);
      g = -1;
      if (ls && ds)          g = m_rr;
      else if (ls)           g = 1;
      else if (ds)           g = 2;
      else if (v[0])         g = 0;
      else if (v[1] && v[2]) g = m_rr;
      else if (v[1])         g = 1;
      else if (v[2])         g = 2;
      h.rdy = (g < 0) ? 3'b000 : 3'(1 << g);
      h.stall = v[0] && (ls || ds);
      for (int i = 1; i < 3; i++)
        m_wait[i] = (v[i] && g != i) ? ((m_wait[i] < LIMIT) ? m_wait[i] + 1 : LIMIT) : 0;
      if (g == 1) m_rr = 2;
      else if (g == 2) m_rr = 1;
      if (g >= 0) begin
        m_we = (a[g] != 5'd0);
        m_wa = a[g];
        m_wd = d[g];
      end else begin
        m_we = 1'b0;
      end
    end
    w.we = m_we; w.wa = m_wa; w.wd = m_wd;
    hs_q.push_back(h);
    wr_q.push_back(w);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Handshake monitor: readys and stall, sampled mid low-phase
  initial begin
    hs_t h;
    forever begin
      @(negedge clk);
      #2;
      if (hs_q.size() > 0) begin
        h = hs_q.pop_front();
        check("ready{dbg,lsu,wb}", 64'({dbg_ready, lsu_ready, wb_ready}), 64'(h.rdy));
        check("wb_stall", 64'(wb_stall), 64'(h.stall));
      end
    end
  end

  // Write-port monitor: registered outputs, sampled just after the edge
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("rf_we", 64'(rf_we), 64'(w.we));
        check("rf_wa", 64'(rf_wa), 64'(w.wa));
        check("rf_wd", 64'(rf_wd), 64'(w.wd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic        r, wv, lv, dv;
    logic [4:0]  wa, la, da;
    logic [31:0] wd, ld, dd;

    // Reset held with every requester asking
    repeat (3) cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3);
    idle();

    // WB beats LSU
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    idle();

    // LSU starves behind WB and preempts it on the fifth cycle
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 1'b1, 5'd15, 32'hAB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Both secondary requesters held: strict alternation
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'(32'h100 + i),
            1'b1, 5'(24 + i), 32'(32'h200 + i));

    // Debug write to x0, then a tie that LSU must win
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'h30, 1'b1, 5'd31, 32'h31);
    idle();

    // Both starve at once behind WB
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    idle();

    // Async reset right after a WB write lands: write to x9 is discarded
    cycle(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_reset_rf_we", 64'(rf_we), 64'd0);
    check("async_reset_rf_wa", 64'(rf_wa), 64'd0);
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 99) != 0);
      wv = ($urandom_range(0, 99) < 70);
      lv = ($urandom_range(0, 99) < 65);
      dv = ($urandom_range(0, 99) < 55);
      wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      la = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      da = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      wd = $urandom;
      ld = $urandom;
      dd = $urandom;
      cycle(r, wv, wa, wd, lv, la, ld, dv, da, dd);
    end
    idle();

    repeat (2) @(posedge clk);
    #3;
    check("hs_queue_drained", 64'(hs_q.size()), 64'd0);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
